direction_sequencer: RTL and testbench

//  Takes 8-bit protected direction words from the route planner, resolves each to a 3-bit

---
 rtl/direction_pkg.sv | 40 ++++
 rtl/dir_fifo.sv | 58 +++++
 rtl/direction_sequencer.sv | 143 ++++++++++++++
 tb/tb_direction_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/direction_pkg.sv
// Shared direction types, state encoding and protected-word resolution helpers
// for the direction sequencer.
package direction_pkg;

  typedef logic [2:0] dir_t;

  localparam dir_t DIR_STOP  = 3'b000;
  localparam dir_t DIR_FWD   = 3'b001;
  localparam dir_t DIR_LEFT  = 3'b010;
  localparam dir_t DIR_RIGHT = 3'b011;
  localparam dir_t DIR_UTURN = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    HALT  = 2'b10
  } seq_state_t;

  function automatic logic parity3(input dir_t d);
    return ^d;
  endfunction

  // Data field is trusted only when the checker bits agree with its parity.
  function automatic logic word_trusted(input logic [7:0] w);
    logic p_s;
    p_s = parity3(w[2:0]);
    return ((w[7:6] == 2'b11) && p_s) || ((w[7:6] == 2'b00) && !p_s);
  endfunction

  function automatic dir_t resolve_dir(input logic [7:0] w);
    dir_t d_s;
    if (word_trusted(w)) begin
      d_s = w[2:0];
    end else begin
      d_s = w[5:3];
    end
    return d_s;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small command FIFO of resolved directions; level separates full from empty
// since the pointers wrap modulo DEPTH.
module dir_fifo
  import direction_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  dir_t                   push_dir,
  input  logic                   pop,
  output dir_t                   head,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  dir_t             mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;

  // Storage, pointers and occupancy; clear wins over any push or pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= DIR_STOP;
      end
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_dir;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push, pop})
        2'b10:   level_r <= level_r + LVL_W'(1'b1);
        2'b01:   level_r <= level_r - LVL_W'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign level = level_r;

endmodule

// File: rtl/direction_sequencer.sv
// Resolves protected direction words, buffers them and issues one at a time to
// the motor controller, halting on a missing ack.
module direction_sequencer
  import direction_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 2**24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             dir_word,
  input  logic                   dir_valid,
  output logic                   dir_ready,
  output logic [2:0]             cmd_dir,
  output logic                   cmd_valid,
  input  logic                   cmd_ack,
  input  logic                   flush,
  output logic                   fault,
  output logic [7:0]             corr_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYC);
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [LVL_W-1:0]   LVL_FULL  = LVL_W'(DEPTH);

  seq_state_t         state_r, state_s;
  dir_t               cmd_dir_r, cmd_dir_s;
  logic               cmd_valid_r, cmd_valid_s;
  logic               fault_r, fault_s;
  logic [TIMER_W-1:0] timer_r, timer_s;
  logic [7:0]         corr_cnt_r;
  logic [LVL_W-1:0]   level_s;
  dir_t               head_s;
  dir_t               res_dir_s;
  logic               res_copy_s;
  logic               push_s;
  logic               pop_s;
  logic               dir_ready_s;

  assign res_dir_s   = resolve_dir(dir_word);
  assign res_copy_s  = !word_trusted(dir_word);
  assign dir_ready_s = (level_s != LVL_FULL) && (state_r != HALT);
  assign push_s      = dir_valid && dir_ready_s && !flush;

  dir_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (flush),
    .push     (push_s),
    .push_dir (res_dir_s),
    .pop      (pop_s),
    .head     (head_s),
    .level    (level_s)
  );

  // Next-state and command output logic; flush overrides every state.
  always_comb begin
    state_s     = state_r;
    cmd_dir_s   = cmd_dir_r;
    cmd_valid_s = cmd_valid_r;
    fault_s     = fault_r;
    timer_s     = timer_r;
    pop_s       = 1'b0;
    if (flush) begin
      state_s     = IDLE;
      cmd_dir_s   = DIR_STOP;
      cmd_valid_s = 1'b0;
      fault_s     = 1'b0;
      timer_s     = {TIMER_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (level_s != {LVL_W{1'b0}}) begin
            pop_s       = 1'b1;
            cmd_dir_s   = head_s;
            cmd_valid_s = 1'b1;
            timer_s     = {TIMER_W{1'b0}};
            state_s     = ISSUE;
          end else begin
            state_s = IDLE;
          end
        end
        ISSUE: begin
          if (cmd_ack) begin
            cmd_valid_s = 1'b0;
            state_s     = IDLE;
          end else if (timer_r == TIMER_MAX) begin
            cmd_dir_s   = DIR_STOP;
            cmd_valid_s = 1'b1;
            fault_s     = 1'b1;
            state_s     = HALT;
          end else begin
            timer_s = timer_r + TIMER_W'(1'b1);
          end
        end
        HALT: begin
          state_s = HALT;
        end
        default: begin
          state_s     = IDLE;
          cmd_dir_s   = DIR_STOP;
          cmd_valid_s = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and registered command outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cmd_dir_r   <= DIR_STOP;
      cmd_valid_r <= 1'b0;
      fault_r     <= 1'b0;
      timer_r     <= {TIMER_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cmd_dir_r   <= cmd_dir_s;
      cmd_valid_r <= cmd_valid_s;
      fault_r     <= fault_s;
      timer_r     <= timer_s;
    end
  end

  // Saturating count of accepted words that fell back to the copy field.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      corr_cnt_r <= 8'h00;
    end else if (push_s && res_copy_s && (corr_cnt_r != 8'hFF)) begin
      corr_cnt_r <= corr_cnt_r + 8'h01;
    end
  end

  assign dir_ready = dir_ready_s;
  assign cmd_dir   = cmd_dir_r;
  assign cmd_valid = cmd_valid_r;
  assign fault     = fault_r;
  assign corr_cnt  = corr_cnt_r;
  assign level     = level_s;

endmodule

// File: tb/tb_direction_sequencer.sv
// Directed self-checking bench for direction_sequencer with DEPTH=4, TIMEOUT_CYC=16.
module tb_direction_sequencer;

  logic       clk;
  logic       reset_n;
  logic [7:0] dir_word;
  logic       dir_valid;
  logic       dir_ready;
  logic [2:0] cmd_dir;
  logic       cmd_valid;
  logic       cmd_ack;
  logic       flush;
  logic       fault;
  logic [7:0] corr_cnt;
  logic [2:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  direction_sequencer #(.DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .dir_word  (dir_word),
    .dir_valid (dir_valid),
    .dir_ready (dir_ready),
    .cmd_dir   (cmd_dir),
    .cmd_valid (cmd_valid),
    .cmd_ack   (cmd_ack),
    .flush     (flush),
    .fault     (fault),
    .corr_cnt  (corr_cnt),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; dir_word = 8'h00; dir_valid = 1'b0; cmd_ack = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("rst_level", level, 0);  chk("rst_valid", cmd_valid, 0);
    chk("rst_dir", cmd_dir, 0);  chk("rst_fault", fault, 0);
    chk("rst_corr", corr_cnt, 0); chk("rst_ready", dir_ready, 1);
    reset_n = 1'b1;
    tick();

    // C1: trusted data 001, issued one cycle after acceptance
    dir_word = 8'hC1; dir_valid = 1'b1; tick(); dir_valid = 1'b0;
    chk("c1_level", level, 1); chk("c1_novalid", cmd_valid, 0);
    tick();
    chk("c1_valid", cmd_valid, 1); chk("c1_dir", cmd_dir, 3'b001);
    chk("c1_lvl0", level, 0); chk("c1_corr", corr_cnt, 0);
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    chk("c1_acked", cmd_valid, 0);

    // C3: parity mismatch -> copy field 000, corr_cnt 1
    dir_word = 8'hC3; dir_valid = 1'b1; tick(); dir_valid = 1'b0;
    chk("c3_corr", corr_cnt, 1);
    tick();
    chk("c3_dir", cmd_dir, 3'b000); chk("c3_valid", cmd_valid, 1);
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;

    // 1B: checker 00 with even parity -> data 011, corr unchanged
    dir_word = 8'h1B; dir_valid = 1'b1; tick(); dir_valid = 1'b0;
    tick();
    chk("1b_dir", cmd_dir, 3'b011); chk("1b_corr", corr_cnt, 1);
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;

    // Five pushes, no ack: one issued, four buffered, FIFO full
    dir_valid = 1'b1;
    dir_word = 8'hC1; tick();
    dir_word = 8'hC2; tick();
    dir_word = 8'h03; tick();
    dir_word = 8'hC4; tick();
    dir_word = 8'h05; tick();
    dir_valid = 1'b0;
    chk("full_level", level, 4); chk("full_ready", dir_ready, 0);
    chk("full_dir", cmd_dir, 3'b001); chk("full_valid", cmd_valid, 1);
    tick();
    chk("hold_dir", cmd_dir, 3'b001);
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    chk("gap_valid", cmd_valid, 0); chk("gap_level", level, 4);
    tick();
    chk("d2_dir", cmd_dir, 3'b010); chk("d2_level", level, 3); chk("d2_ready", dir_ready, 1);
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    chk("d2_gap", cmd_valid, 0);
    tick();
    chk("d3_dir", cmd_dir, 3'b011); chk("d3_level", level, 2);
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;

    // Push on the same edge as a pop at level 2 -> level stays 2
    dir_word = 8'hC7; dir_valid = 1'b1; tick(); dir_valid = 1'b0;
    chk("pp_level", level, 2); chk("d4_dir", cmd_dir, 3'b100);
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    tick();
    chk("d5_dir", cmd_dir, 3'b101); chk("d5_level", level, 1);
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    tick();
    chk("d6_dir", cmd_dir, 3'b111); chk("d6_level", level, 0);
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    chk("d6_acked", cmd_valid, 0);

    // Timeout: 15 cycles still waiting, 16th raises fault
    dir_word = 8'hC2; dir_valid = 1'b1; tick(); dir_valid = 1'b0;
    tick();
    repeat (15) tick();
    chk("to_early_fault", fault, 0); chk("to_early_dir", cmd_dir, 3'b010);
    tick();
    chk("to_fault", fault, 1); chk("to_dir", cmd_dir, 3'b000);
    chk("to_valid", cmd_valid, 1); chk("to_ready", dir_ready, 0);
    cmd_ack = 1'b1; dir_word = 8'hC1; dir_valid = 1'b1; tick();
    cmd_ack = 1'b0; dir_valid = 1'b0;
    chk("halt_fault", fault, 1); chk("halt_valid", cmd_valid, 1); chk("halt_level", level, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_fault", fault, 0); chk("fl_level", level, 0);
    chk("fl_valid", cmd_valid, 0); chk("fl_ready", dir_ready, 1);
    dir_word = 8'hC4; dir_valid = 1'b1; tick(); dir_valid = 1'b0;
    tick();
    chk("post_fl_dir", cmd_dir, 3'b100); chk("post_fl_valid", cmd_valid, 1);
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;

    // Async reset while issuing with three buffered words
    dir_valid = 1'b1;
    dir_word = 8'hC1; tick();
    dir_word = 8'hC2; tick();
    dir_word = 8'h03; tick();
    dir_word = 8'hC4; tick();
    dir_valid = 1'b0;
    chk("pre_rst_level", level, 3); chk("pre_rst_valid", cmd_valid, 1);
    reset_n = 1'b0; #1;
    chk("mid_rst_level", level, 0); chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_dir", cmd_dir, 0); chk("mid_rst_corr", corr_cnt, 0);
    tick(); reset_n = 1'b1; tick();

    // Flush drops a concurrent push; corr_cnt survives flush
    dir_word = 8'hC3; dir_valid = 1'b1; flush = 1'b1; tick();
    dir_valid = 1'b0; flush = 1'b0;
    chk("drop_level", level, 0); chk("drop_corr", corr_cnt, 0);
    dir_valid = 1'b1; tick(); dir_valid = 1'b0;
    tick();
    chk("cp_corr", corr_cnt, 1); chk("cp_dir", cmd_dir, 3'b000); chk("cp_valid", cmd_valid, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl2_corr", corr_cnt, 1); chk("fl2_valid", cmd_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
